// File: rtl/adc_sync_demod_if.sv
// -----------------------------------------------------------------------------
// adc_sync_demod_if
//   Signal bundle between the synchronous demodulator and its environment
//   (sine generator control, serial ADC pins, acquisition readout).
//
//   Modports:
//     master : the demodulator. Takes start_conv/halfcycle/new_period/adc_sdo,
//              drives ADC pins, result bus, status and debug state.
//     slave  : the environment (sine generator, ADC, readout).
//
//   Handshake: result/result_cnt are qualified by result_valid, a one-cycle
//   strobe with no back-pressure; the consumer must take the value in the
//   cycle result_valid is high. start_conv and new_period are levels whose
//   rising edges are the events.
//
//   dbg_state carries the demodulator FSM state encoding for observation.
// -----------------------------------------------------------------------------
interface adc_sync_demod_if #(
   parameter int ACC_W = 20,
   parameter int CNT_W = 8
);
   logic             start_conv;
   logic             halfcycle;
   logic             new_period;
   logic             adc_sdo;
   logic             adc_cs_n;
   logic             adc_sclk;
   logic [ACC_W-1:0] result;
   logic [CNT_W-1:0] result_cnt;
   logic             result_valid;
   logic             busy;
   logic             overrun;
   logic [2:0]       dbg_state;

   modport master (
      input  start_conv, halfcycle, new_period, adc_sdo,
      output adc_cs_n, adc_sclk, result, result_cnt, result_valid,
             busy, overrun, dbg_state
   );

   modport slave (
      output start_conv, halfcycle, new_period, adc_sdo,
      input  adc_cs_n, adc_sclk, result, result_cnt, result_valid,
             busy, overrun, dbg_state
   );
endinterface

// File: rtl/adc_sync_demod.sv
// -----------------------------------------------------------------------------
// adc_sync_demod
//   Synchronous demodulator behind the sine generator. Each start_conv rising
//   edge reads one ADC_BITS-wide sample (MSB first) from a serial ADC over
//   CS/SCLK/SDO and adds it to (halfcycle=1) or subtracts it from
//   (halfcycle=0) a per-period accumulator. Each new_period rising edge
//   closes the period: the sum and sample count are published on
//   result/result_cnt with a one-cycle result_valid strobe.
//
//   Ports:
//     clk  : system clock, single domain
//     rst  : synchronous, active-high reset
//     bus  : adc_sync_demod_if.master
//            start_conv, halfcycle, new_period, adc_sdo  (inputs)
//            adc_cs_n, adc_sclk                           (registered ADC pins)
//            result, result_cnt, result_valid             (period result)
//            busy, overrun                                (status)
//            dbg_state                                    (FSM state)
//
//   Timing for a start edge sampled at cycle T (SCLK_DIV=4, ADC_BITS=12):
//     adc_cs_n low and busy high from T+1, first SCLK rise at T+1+2*SCLK_DIV,
//     DONE at T+1+SCLK_DIV*(1+2*ADC_BITS). CS is already high in DONE, busy
//     drops after it; the accumulator reflects the sample from DONE+1.
// -----------------------------------------------------------------------------
module adc_sync_demod #(
   parameter int ADC_BITS = 12,
   parameter int SCLK_DIV = 4,
   parameter int ACC_W    = 20,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   adc_sync_demod_if.master bus
);

   localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
   localparam int BIT_W = $clog2(ADC_BITS + 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CSS     = 3'd1,
      S_SCLK_LO = 3'd2,
      S_SCLK_HI = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t               state;
   logic [DIV_W-1:0]     div_cnt;
   logic [BIT_W-1:0]     bits_left;
   logic [ADC_BITS-1:0]  shreg;
   logic                 sign;
   logic                 sc_d;
   logic                 np_d;
   logic                 cs_n_r;
   logic                 sclk_r;
   logic                 busy_r;
   logic                 overrun_r;
   logic [ACC_W-1:0]     acc;
   logic [CNT_W-1:0]     cnt;
   logic [ACC_W-1:0]     result_r;
   logic [CNT_W-1:0]     result_cnt_r;
   logic                 result_valid_r;

   logic                 sc_edge;
   logic                 np_edge;
   logic                 div_last;
   logic [ACC_W-1:0]     sample;
   logic [ACC_W-1:0]     acc_next;
   logic [CNT_W-1:0]     cnt_next;

   assign sc_edge  = bus.start_conv & ~sc_d;
   assign np_edge  = bus.new_period & ~np_d;
   assign div_last = (div_cnt == DIV_W'(SCLK_DIV - 1));

   // Sample is unsigned; the cast zero-extends into the accumulator width.
   assign sample = ACC_W'(shreg);

   // Accumulator value including the DONE-cycle contribution. A close in the
   // same cycle as DONE publishes this value, so the sample is never lost.
   always_comb begin
      acc_next = acc;
      cnt_next = cnt;
      if (state == S_DONE) begin
         acc_next = sign ? (acc + sample) : (acc - sample);
         cnt_next = cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         div_cnt        <= '0;
         bits_left      <= '0;
         shreg          <= '0;
         sign           <= 1'b0;
         sc_d           <= 1'b0;
         np_d           <= 1'b0;
         cs_n_r         <= 1'b1;
         sclk_r         <= 1'b0;
         busy_r         <= 1'b0;
         overrun_r      <= 1'b0;
         acc            <= '0;
         cnt            <= '0;
         result_r       <= '0;
         result_cnt_r   <= '0;
         result_valid_r <= 1'b0;
      end else begin
         sc_d           <= bus.start_conv;
         np_d           <= bus.new_period;
         result_valid_r <= 1'b0;

         // Any start edge outside IDLE (DONE included) is dropped and flagged.
         if (sc_edge && (state != S_IDLE)) begin
            overrun_r <= 1'b1;
         end

         // Period close wins over accumulation: the old period gets the
         // DONE contribution, the new period starts empty.
         if (np_edge) begin
            result_r       <= acc_next;
            result_cnt_r   <= cnt_next;
            result_valid_r <= 1'b1;
            acc            <= '0;
            cnt            <= '0;
         end else begin
            acc <= acc_next;
            cnt <= cnt_next;
         end

         case (state)
            S_IDLE: begin
               if (sc_edge) begin
                  sign    <= bus.halfcycle;
                  cs_n_r  <= 1'b0;
                  busy_r  <= 1'b1;
                  div_cnt <= '0;
                  state   <= S_CSS;
               end
            end

            S_CSS: begin
               if (div_last) begin
                  div_cnt   <= '0;
                  bits_left <= BIT_W'(ADC_BITS);
                  state     <= S_SCLK_LO;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end

            S_SCLK_LO: begin
               if (div_last) begin
                  // Sample SDO at the end of the low phase, just before the
                  // rising SCLK edge; MSB arrives first and shifts upward.
                  shreg     <= ADC_BITS'({shreg, bus.adc_sdo});
                  bits_left <= bits_left - 1'b1;
                  sclk_r    <= 1'b1;
                  div_cnt   <= '0;
                  state     <= S_SCLK_HI;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end

            S_SCLK_HI: begin
               if (div_last) begin
                  sclk_r  <= 1'b0;
                  div_cnt <= '0;
                  if (bits_left != '0) begin
                     state <= S_SCLK_LO;
                  end else begin
                     cs_n_r <= 1'b1;
                     state  <= S_DONE;
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end

            S_DONE: begin
               busy_r <= 1'b0;
               state  <= S_IDLE;
            end

            default: begin
               cs_n_r <= 1'b1;
               sclk_r <= 1'b0;
               busy_r <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.adc_cs_n     = cs_n_r;
   assign bus.adc_sclk     = sclk_r;
   assign bus.result       = result_r;
   assign bus.result_cnt   = result_cnt_r;
   assign bus.result_valid = result_valid_r;
   assign bus.busy         = busy_r;
   assign bus.overrun      = overrun_r;
   assign bus.dbg_state    = state;

endmodule
